// File: rtl/alu_branch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_branch_unit_if : operand/branch inputs and result outputs of the  |
// | ALU + branch unit. Revision: 1.0                                      |
// +----------------------------------------------------------------------+
interface alu_branch_unit_if #(
    parameter int XLEN = 32
);
    logic [2:0]      aluop;
    logic [5:0]      funct;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [4:0]      shamt;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] branch_address;
    logic [1:0]      branch_control;
    logic [XLEN-1:0] alu_out;
    logic [2:0]      flag;
    logic            carry_q;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_plus;
    logic            taken;

    modport master (
        output aluop, funct, in1, in2, shamt, pc_in, branch_address, branch_control,
        input  alu_out, flag, carry_q, pc_next, pc_plus, taken
    );

    modport slave (
        input  aluop, funct, in1, in2, shamt, pc_in, branch_address, branch_control,
        output alu_out, flag, carry_q, pc_next, pc_plus, taken
    );
endinterface
`default_nettype wire

// File: rtl/alu_branch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_branch_unit : combinational ALU with registered carry and branch  |
// | resolution. Optional macro ALU_DIFF_OP_EN enables the diff op.        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module alu_branch_unit #(
    parameter int XLEN = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_branch_unit_if.slave   bus
);
    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_COMP  = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_XOR   = 4'h3;
    localparam logic [3:0] OP_SHLL  = 4'h4;
    localparam logic [3:0] OP_SHRL  = 4'h5;
    localparam logic [3:0] OP_SHLLV = 4'h6;
    localparam logic [3:0] OP_SHRLV = 4'h7;
    localparam logic [3:0] OP_SHRA  = 4'h8;
    localparam logic [3:0] OP_SHRAV = 4'h9;
    localparam logic [3:0] OP_DIFF  = 4'hA;
    localparam logic [3:0] OP_F     = 4'hF;

    logic [3:0]      ctrl;
    logic [XLEN:0]   sum_ext;
    logic [XLEN:0]   comp_ext;
    logic [XLEN-1:0] diff_vec;
    logic [5:0]      diff_idx;
    logic [XLEN-1:0] result;
    logic            carry;
    logic            carry_d;
    logic            carry_q;

    always_comb begin
        ctrl = OP_F;
        case (bus.aluop)
            3'b000: begin
                case (bus.funct)
                    6'h00: ctrl = OP_ADD;
                    6'h01: ctrl = OP_COMP;
                    6'h02: ctrl = OP_AND;
                    6'h03: ctrl = OP_XOR;
                    6'h04: ctrl = OP_SHLL;
                    6'h05: ctrl = OP_SHRL;
                    6'h06: ctrl = OP_SHLLV;
                    6'h07: ctrl = OP_SHRLV;
                    6'h08: ctrl = OP_SHRA;
                    6'h09: ctrl = OP_SHRAV;
`ifdef ALU_DIFF_OP_EN
                    6'h0A: ctrl = OP_DIFF;
`else
                    6'h0A: ctrl = OP_F;
`endif
                    default: ctrl = OP_F;
                endcase
            end
            3'b001:  ctrl = OP_ADD;
            3'b010:  ctrl = OP_COMP;
            default: ctrl = OP_F;
        endcase
    end

    assign sum_ext  = {1'b0, bus.in1} + {1'b0, bus.in2};
    assign comp_ext = {1'b0, ~bus.in2} + {{XLEN{1'b0}}, 1'b1};
    assign diff_vec = bus.in1 ^ bus.in2;

    // Scan from the MSB down so the last hit is the least-significant differing bit.
    always_comb begin
        diff_idx = 6'd32;
        for (int i = XLEN - 1; i >= 0; i--) begin
            if (diff_vec[i]) begin
                diff_idx = 6'(i);
            end
        end
    end

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (ctrl)
            OP_ADD:   begin result = sum_ext[XLEN-1:0];  carry = sum_ext[XLEN];  end
            OP_COMP:  begin result = comp_ext[XLEN-1:0]; carry = comp_ext[XLEN]; end
            OP_AND:   result = bus.in1 & bus.in2;
            OP_XOR:   result = bus.in1 ^ bus.in2;
            OP_SHLL:  result = bus.in1 << bus.shamt;
            OP_SHRL:  result = bus.in1 >> bus.shamt;
            OP_SHLLV: result = bus.in1 << bus.in2[4:0];
            OP_SHRLV: result = bus.in1 >> bus.in2[4:0];
            OP_SHRA:  result = $signed(bus.in1) >>> bus.shamt;
            OP_SHRAV: result = $signed(bus.in1) >>> bus.in2[4:0];
            OP_DIFF:  result = {{(XLEN-6){1'b0}}, diff_idx};
            default:  result = '0;
        endcase
    end

    assign bus.alu_out = result;
    assign bus.flag    = {carry, (result == '0), result[XLEN-1]};

    assign carry_d = ((ctrl == OP_ADD) || (ctrl == OP_COMP)) ? carry : carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign bus.carry_q = carry_q;

    logic [XLEN-1:0] pc_plus_raw;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] dest;
    logic            take;

    assign pc_plus_raw = bus.pc_in + XLEN'(4);
    assign target      = pc_plus_raw + (bus.branch_address << 2);

    // Conditional branches see carry_q from before the edge, not this cycle's ALU carry.
    always_comb begin
        take = 1'b0;
        dest = target;
        case (bus.branch_control)
            2'b01: begin
                case (bus.funct[4:0])
                    5'h00:   take = 1'b1;
                    5'h01:   begin take = 1'b1; dest = bus.in1; end
                    5'h02:   take = 1'b1;
                    default: take = 1'b0;
                endcase
            end
            2'b10: begin
                case (bus.funct[4:0])
                    5'h00:   take = bus.in1[XLEN-1];
                    5'h01:   take = (bus.in1 == '0);
                    5'h02:   take = (bus.in1 != '0);
                    5'h03:   take = carry_q;
                    5'h04:   take = !carry_q;
                    default: take = 1'b0;
                endcase
            end
            default: take = 1'b0;
        endcase
    end

    assign bus.pc_plus = rst_n ? pc_plus_raw : '0;
    assign bus.taken   = rst_n & take;
    assign bus.pc_next = !rst_n ? '0 : (take ? dest : pc_plus_raw);
endmodule
`default_nettype wire

// File: tb/tb_alu_branch_unit.sv
`default_nettype none
// Randomized + directed bench for alu_branch_unit against an arithmetic reference model.
module tb_alu_branch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   m_carry = 1'b0;

    alu_branch_unit_if #(.XLEN(32)) bus();
    alu_branch_unit #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint signed to_signed(input logic [31:0] v);
        return v[31] ? longint'(v) - 64'sd4294967296 : longint'(v);
    endfunction

    // Returns the op number (-1 means code F) chosen by aluop/funct.
    function automatic int op_of(input logic [2:0] ao, input logic [5:0] fn);
        if (ao == 3'd1) return 0;
        if (ao == 3'd2) return 1;
        if (ao != 3'd0) return -1;
        if (fn <= 6'd9) return int'(fn);
`ifdef ALU_DIFF_OP_EN
        if (fn == 6'd10) return 10;
`endif
        return -1;
    endfunction

    function automatic void model_alu(input logic [2:0] ao, input logic [5:0] fn,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [4:0] sh, output logic [31:0] res,
                                      output bit cy);
        longint unsigned two32 = 64'd4294967296;
        longint unsigned ua = longint'(a);
        longint unsigned ub = longint'(b);
        longint signed   sa, d, q;
        int              amt;
        int              op = op_of(ao, fn);
        res = 32'd0;
        cy  = 1'b0;
        amt = (op == 6 || op == 7 || op == 9) ? int'(b % 32) : int'(sh);
        case (op)
            0: begin res = 32'((ua + ub) % two32); cy = (ua + ub) >= two32; end
            1: begin res = 32'((two32 - ub) % two32); cy = (b == 0); end
            2: res = a & b;
            3: res = a ^ b;
            4, 6: res = 32'((ua * (64'd1 << amt)) % two32);
            5, 7: res = 32'(ua / (64'd1 << amt));
            8, 9: begin
                sa = to_signed(a);
                d  = longint'(64'd1 << amt);
                q  = sa / d;
                if ((sa % d) != 0 && sa < 0) q = q - 1;
                res = 32'(q);
            end
            10: begin
                res = 32'd32;
                for (int i = 0; i < 32; i++) begin
                    if (a[i] != b[i]) begin
                        res = 32'(i);
                        break;
                    end
                end
            end
            default: res = 32'd0;
        endcase
    endfunction

    task automatic drive(input logic [2:0] ao, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic [31:0] pc,
                         input logic [31:0] ba, input logic [1:0] bc);
        bus.aluop = ao; bus.funct = fn; bus.in1 = a; bus.in2 = b; bus.shamt = sh;
        bus.pc_in = pc; bus.branch_address = ba; bus.branch_control = bc;
    endtask

    // Checks combinational outputs, clocks once, then checks the registered carry.
    task automatic check_vector();
        logic [31:0] res, plus, tgt, nxt;
        bit          cy, tk;
        int          f;
        model_alu(bus.aluop, bus.funct, bus.in1, bus.in2, bus.shamt, res, cy);
        plus = bus.pc_in + 32'd4;
        tgt  = plus + bus.branch_address * 32'd4;
        f    = int'(bus.funct % 32);
        tk   = 1'b0;
        nxt  = plus;
        if (bus.branch_control == 2'b01) begin
            if (f == 0 || f == 2) begin tk = 1'b1; nxt = tgt; end
            else if (f == 1) begin tk = 1'b1; nxt = bus.in1; end
        end else if (bus.branch_control == 2'b10) begin
            case (f)
                0: tk = bus.in1[31];
                1: tk = (bus.in1 == 0);
                2: tk = (bus.in1 != 0);
                3: tk = m_carry;
                4: tk = !m_carry;
                default: tk = 1'b0;
            endcase
            if (tk) nxt = tgt;
        end
        #1;
        check("alu_out", bus.alu_out, res);
        check("flag", {29'd0, bus.flag}, {29'd0, cy, res == 0, res[31]});
        check("pc_plus", bus.pc_plus, plus);
        check("pc_next", bus.pc_next, nxt);
        check("taken", {31'd0, bus.taken}, {31'd0, tk});
        @(posedge clk);
        if (op_of(bus.aluop, bus.funct) == 0 || op_of(bus.aluop, bus.funct) == 1) m_carry = cy;
        #1;
        check("carry_q", {31'd0, bus.carry_q}, {31'd0, m_carry});
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a, b;
        drive(3'd0, 6'h00, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h100, 32'd4, 2'b01);
        #2;
        check("rst_carry_q", {31'd0, bus.carry_q}, 32'd0);
        check("rst_pc_next", bus.pc_next, 32'd0);
        check("rst_pc_plus", bus.pc_plus, 32'd0);
        check("rst_taken", {31'd0, bus.taken}, 32'd0);
        check("rst_alu_out", bus.alu_out, 32'd0);
        check("rst_flag", {29'd0, bus.flag}, 32'b110);
        @(negedge clk);
        rst_n = 1'b1;

        // add wraps to zero with carry out
        drive(3'd0, 6'h00, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0, 32'h0, 2'b00);
        #1;
        check("add_wrap_out", bus.alu_out, 32'd0);
        check("add_wrap_flag", {29'd0, bus.flag}, 32'b110);
        check_vector();
        check("add_wrap_carry_q", {31'd0, bus.carry_q}, 32'd1);

        // bcy with carry held; same-cycle add leaves no carry but decision uses held one
        drive(3'd0, 6'h03, 32'd0, 32'd0, 5'd0, 32'h100, 32'd4, 2'b10);
        #1;
        check("bcy_pc_next", bus.pc_next, 32'h114);
        check("bcy_taken", {31'd0, bus.taken}, 32'd1);
        check_vector();
        drive(3'd1, 6'h04, 32'd1, 32'd1, 5'd0, 32'h100, 32'd4, 2'b10);
        #1;
        check("bncy_uses_old_carry", {31'd0, bus.taken}, 32'd0);
        check_vector();

        drive(3'd0, 6'h08, 32'h8000_0000, 32'd0, 5'd4, 32'd0, 32'd0, 2'b00);
        #1;
        check("shra_out", bus.alu_out, 32'hF800_0000);
        check("shra_sign", {31'd0, bus.flag[0]}, 32'd1);
        check_vector();
        drive(3'd2, 6'h3F, 32'd0, 32'd5, 5'd0, 32'd0, 32'd0, 2'b00);
        #1;
        check("comp_out", bus.alu_out, 32'hFFFF_FFFB);
        check_vector();

        drive(3'd0, 6'h01, 32'h40, 32'd0, 5'd0, 32'h200, 32'd7, 2'b01);
        #1;
        check("br_pc_next", bus.pc_next, 32'h40);
        check("br_pc_plus", bus.pc_plus, 32'h204);
        check_vector();

        drive(3'd0, 6'h0A, 32'h8, 32'hC, 5'd0, 32'd0, 32'd0, 2'b00);
        #1;
`ifdef ALU_DIFF_OP_EN
        check("diff_8_c", bus.alu_out, 32'd2);
`else
        check("diff_off", bus.alu_out, 32'd0);
        check("diff_off_zero", {31'd0, bus.flag[1]}, 32'd1);
`endif
        check_vector();
        drive(3'd0, 6'h0A, 32'h1234_5678, 32'h1234_5678, 5'd0, 32'd0, 32'd0, 2'b00);
        #1;
`ifdef ALU_DIFF_OP_EN
        check("diff_equal", bus.alu_out, 32'd32);
`else
        check("diff_equal_off", bus.alu_out, 32'd0);
`endif
        check_vector();

        for (int k = 0; k < 400; k++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = a;
                1: b = 32'd0;
                2: a = 32'd0;
                3: b = a ^ (32'd1 << $urandom_range(0, 31));
                default: ;
            endcase
            drive(($urandom_range(0, 3) != 0) ? 3'd0 : 3'($urandom_range(0, 7)),
                  6'($urandom_range(0, 15)), a, b, 5'($urandom), $urandom, $urandom,
                  2'($urandom_range(0, 3)));
            check_vector();
        end

        // async reset mid-cycle: set carry, then drop rst_n away from any edge
        drive(3'd0, 6'h00, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h300, 32'd1, 2'b01);
        check_vector();
        check("pre_rst_carry_q", {31'd0, bus.carry_q}, 32'd1);
        #2;
        rst_n = 1'b0;
        m_carry = 1'b0;
        #1;
        check("async_rst_carry_q", {31'd0, bus.carry_q}, 32'd0);
        check("async_rst_pc_next", bus.pc_next, 32'd0);
        check("async_rst_taken", {31'd0, bus.taken}, 32'd0);
        check("async_rst_alu_out", bus.alu_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'd0, 6'h04, 32'd0, 32'd0, 5'd0, 32'h10, 32'd0, 2'b10);
        check_vector();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_branch_unit.md
ALU_BRANCH_UNIT -- requirements
Module: alu_branch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is required to be supported.
REQ-002 SHALL have port clock, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports aluop (input, 3, main-decoder ALU class) and funct (input, 6, instruction[5:0]).
REQ-005 SHALL have ports in1 (input, 32, rs value) and in2 (input, 32, rt or immediate, pre-muxed).
REQ-006 SHALL have port shamt, input, 5, constant shift amount.
REQ-007 SHALL have ports pc_in (input, 32, current PC) and branch_address (input, 32, sign-extended word offset).
REQ-008 SHALL have port branch_control, input, 2: 00 none, 01 unconditional, 10 conditional, 11 reserved.
REQ-009 SHALL have ports alu_out (output, 32), flag (output, 3, {carry, zero, sign}, combinational) and carry_q (output, 1, registered carry).
REQ-010 SHALL have ports pc_next (output, 32), pc_plus (output, 32, link value) and taken (output, 1).

Function
REQ-011 SHALL decode a 4-bit control: aluop 000 selects by funct; 001 add; 010 comp; any other aluop selects code F.
REQ-012 SHALL map funct codes: 00 add, 01 comp, 02 and, 03 xor, 04 shll, 05 shrl, 06 shllv, 07 shrlv, 08 shra, 09 shrav, 0A diff; any other funct gives code F.
REQ-013 SHALL compute add = in1+in2 (mod 2^32) with carry = bit 32 of the 33-bit sum.
REQ-014 SHALL compute comp = ~in2+1, with carry = carry-out of that increment (1 only when in2 = 0).
REQ-015 SHALL implement shll/shrl/shra by shamt, and shllv/shrlv/shrav by in2[4:0]; shra/shrav replicate in1[31].
REQ-016 SHALL compute diff = index (0-31) of the least-significant bit where in1 and in2 differ, or 32 when they are equal.
REQ-017 SHALL output alu_out = 0 for code F.
REQ-018 SHALL set carry = 0 for all logic and shift operations.
REQ-019 SHALL set zero = (alu_out == 0) and sign = alu_out[31] for every operation.
REQ-020 SHALL load carry_q from flag[2] on each rising clock edge where the code is add or comp, and hold it otherwise.
REQ-021 SHALL compute pc_plus = pc_in + 4 at all times outside reset.
REQ-022 SHALL compute target = pc_plus + (branch_address << 2), with wrap-around modulo 2^32.
REQ-023 SHALL decode unconditional branches by funct[4:0]: 00 b -> target, 01 br -> in1, 02 bl -> target (caller writes pc_plus); other values not taken.
REQ-024 SHALL decode conditional branches by funct[4:0]: 00 bltz (in1[31]), 01 bz (in1 == 0), 02 bnz (in1 != 0), 03 bcy (carry_q), 04 bncy (!carry_q); other values not taken.
REQ-025 SHALL output taken = 1 and pc_next = the selected destination when a branch is taken, and otherwise pc_next = pc_plus with taken = 0.
REQ-026 SHALL make bcy/bncy use carry_q as held before the current edge, so a same-cycle add does not affect the decision.

Reset
REQ-027 SHALL clear carry_q to 0 immediately while reset is low, independent of clock.
REQ-028 SHALL force pc_next = 0, pc_plus = 0 and taken = 0 while reset is low.
REQ-029 SHALL keep alu_out and flag purely combinational and unaffected by reset.

Configuration
REQ-030 SHALL gate the diff operation with macro ALU_DIFF_OP_EN: when defined, funct 0A gives diff; when undefined, funct 0A gives code F (alu_out = 0, zero = 1).

Verification
REQ-031 SHALL cover: aluop 000, funct 00, in1 = FFFFFFFF, in2 = 1 -> alu_out 0, flag 3'b110, and carry_q = 1 after the edge.
REQ-032 SHALL cover: carry_q = 1, branch_control 10, funct 03, pc_in = 100, branch_address = 4 -> pc_next = 114, taken = 1.
REQ-033 SHALL cover: funct 08, shamt 4, in1 = 80000000 -> F8000000, sign = 1; and aluop 010, in2 = 5 -> FFFFFFFB.
REQ-034 SHALL cover: branch_control 01, funct 01, in1 = 40, pc_in = 200 -> pc_next = 40, pc_plus = 204.
REQ-035 SHALL cover diff: in1 = 8, in2 = C -> 2; in1 = in2 -> 32; and the same stimulus with the macro undefined -> 0.
REQ-036 SHALL cover: reset driven low between clock edges with carry_q = 1 -> carry_q = 0 and pc_next = 0 immediately.
